spi_gpio_expander_p: RTL and testbench
======================================

Name: spi_gpio_expander_p

Overview:
Parametrised SPI-slave GPIO expander and next-generation GPIO expander block. GPIO width and SPI mode are configurable, and it adds readback, per-pin direction, auto-increment burst access and a change-detect interrupt. All SPI pins are oversampled in the system clock domain, so there is no sclk clock domain. Sits between the external microcontroller SPI pins and the chip GPIO pads.

Parameters:
GPIO_W, 16, number of GPIO pins; multiple of 8, range 8..32
CPOL, 0, sclk idle level
CPHA, 0, 0 = sample on leading edge, shift on trailing edge; 1 = the reverse
SS_ACTIVE, 1, active level of ss (1 = frame while ss high)

Ports:
clk  input  1  system clock; must be at least 8x the sclk frequency
rst  input  1  asynchronous, active-high reset
ss  input  1  SPI slave select, active level set by SS_ACTIVE
sclk  input  1  SPI clock
mosi  input  1  SPI data in, MSB first
miso  output  1  SPI data out, MSB first
miso_oe  output  1  pad enable for miso
gpio_in  input  GPIO_W  pad input values
gpio_out  output  GPIO_W  pad output values (OUT register)
gpio_oe  output  GPIO_W  pad output enables (DIR register, 1 = output)
irq  output  1  level interrupt, registered

Behaviour:
- Synchronisers and edge detect:
  - ss, sclk, mosi and gpio_in each pass through 2-flop synchronisers; edges are detected on the synchronised versions.
  - Leading edge = sclk transition away from CPOL.
- Registers (each GPIO_W wide, 3-bit address):
  - 0 OUT (RW)
  - 1 DIR (RW)
  - 2 IN (RO, synchronised gpio_in)
  - 3 MASK (RW)
  - 4 STATUS (W1C)
  - 5 ID (RO, GPIO_W zero-extended)
  - 6, 7 reserved: read as 0, writes ignored.
  - Writes to RO registers are ignored.
- Frame format: one command byte, then data bytes.
  - Command byte: cmd[7] = 1 write / 0 read; cmd[6:4] = start address; cmd[3:0] ignored.
  - Each register takes GPIO_W/8 data bytes, least-significant byte first, MSB first within each byte.
  - After the last byte of a register, the address auto-increments, wrapping 7 -> 0.
- FSM:
  - IDLE -> CMD on ss becoming active.
  - CMD -> DATA after 8 sampling edges.
  - DATA stays in DATA, one byte counter per register.
  - Any state -> IDLE on ss becoming inactive.
  - A 3-bit bit counter and a byte counter reset on every ss assertion.
- Writes:
  - Bytes accumulate in a GPIO_W shadow register.
  - The target register commits only when its final byte completes.
  - gpio_out and gpio_oe update at most 4 clk cycles after the final sampling edge at the pins.
  - Partial registers are discarded when ss deasserts; registers already committed in the frame are kept.
- Reads:
  - The addressed register is snapshotted when the command byte completes and shifted out over the following bytes.
  - The next register is snapshotted at each register boundary.
- miso during the command byte shifts out the marker 8'h5A.
  - CPHA=0: the first bit is driven when ss is detected active.
  - CPHA=1: the first bit is driven on the first leading edge.
- miso_oe = synchronised ss active. miso = 0 whenever miso_oe = 0.
- Interrupt:
  - STATUS[i] sets on any change of synchronised gpio_in[i] while MASK[i] = 1.
  - irq = |STATUS, registered (one cycle).
  - If a W1C clear and a set hit the same bit in the same cycle, set wins.
  - Changes on bits with MASK = 0 never set STATUS.
- Reset (asynchronous):
  - OUT, DIR, MASK, STATUS = 0, so gpio_out = 0 and gpio_oe = 0 (all pins are inputs).
  - irq = 0, miso = 0, miso_oe = 0.
  - FSM = IDLE; counters and shadow registers cleared.
  - Reset during a frame aborts it; the SPI FSM stays idle until the next ss assertion after reset release.
- If ss is already active at reset release, there is no frame until ss deasserts and reasserts.

Test Plan:
- Reset: assert rst mid-frame -> gpio_out = 0, gpio_oe = 0, irq = 0, miso_oe = 0 immediately. A frame sent without first deasserting ss is ignored.
- Write OUT (GPIO_W=16, mode 0): cmd 0x80, data 0xC3, 0xA5 -> gpio_out = 16'hA5C3 within 4 clk of the last edge; gpio_oe stays 0.
- Burst write: cmd 0x80, data FF 00 0F 0F -> gpio_out = 16'h00FF, gpio_oe = 16'h0F0F. Repeat with CPOL=1, CPHA=1 -> identical result.
- Read IN: gpio_in = 16'h1234, cmd 0x20, 2 dummy bytes -> miso = 0x5A during the command byte, then 0x34, then 0x12. Read ID (cmd 0x50) -> 0x10, 0x00.
- Abort: cmd 0x80, data 0xFF, then ss deasserted -> gpio_out unchanged. A next full frame still works.
- IRQ: write MASK = 16'h0008 (cmd 0xB0, 08 00), toggle gpio_in[3] -> irq = 1 within 4 clk and STATUS = 0x0008. Toggling gpio_in[2] leaves STATUS unchanged. W1C write cmd 0xC0, data 08 00 -> irq = 0.

Source files
------------

// File: rtl/spi_gpio_expander_p.sv
// SPI-slave GPIO expander. All SPI pins are oversampled in the clk domain. The block provides
// OUT/DIR/IN/MASK/STATUS/ID registers, auto-increment bursts and a change-detect interrupt.
module spi_gpio_expander_p #(
  parameter int unsigned GPIO_W    = 16,
  parameter bit          CPOL      = 1'b0,
  parameter bit          CPHA      = 1'b0,
  parameter bit          SS_ACTIVE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);

  localparam int unsigned       NB       = GPIO_W / 8;
  localparam logic [1:0]        LastByte = 2'(NB - 1);
  localparam logic [GPIO_W-1:0] IdVal    = GPIO_W'(GPIO_W);

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  logic [1:0]        ss_sync, sclk_sync, mosi_sync;
  logic [GPIO_W-1:0] gin_meta, gin_sync, gin_prev;
  logic              sclk_prev, ss_act_prev;
  logic              ss_act, sclk_s, mosi_s, sclk_edge, lead_edge, trail_edge;
  logic              sample_edge, shift_edge, start;

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d, addr_q, addr_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        rx_q, rx_d, tx_q, tx_d;
  logic              wr_q, wr_d, first_q, first_d, armed_q, armed_d, irq_q, irq_d;
  logic [GPIO_W-1:0] shadow_q, shadow_d, snap_q, snap_d;
  logic [GPIO_W-1:0] out_q, out_d, dir_q, dir_d, mask_q, mask_d, status_q, status_d;

  logic [7:0]        rx_byte, tx_load;
  logic [GPIO_W-1:0] merged, w1c;
  logic [2:0]        addr_nx;

  // The ss synchroniser resets to the active level so a frame already in progress at reset
  // release never looks like a fresh assertion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync     <= {2{SS_ACTIVE}};
      sclk_sync   <= {2{CPOL}};
      mosi_sync   <= '0;
      gin_meta    <= '0;
      gin_sync    <= '0;
      gin_prev    <= '0;
      sclk_prev   <= CPOL;
      ss_act_prev <= 1'b1;
    end else begin
      ss_sync     <= {ss_sync[0], ss};
      sclk_sync   <= {sclk_sync[0], sclk};
      mosi_sync   <= {mosi_sync[0], mosi};
      gin_meta    <= gpio_in;
      gin_sync    <= gin_meta;
      gin_prev    <= gin_sync;
      sclk_prev   <= sclk_s;
      ss_act_prev <= ss_act;
    end
  end

  assign ss_act      = (ss_sync[1] == SS_ACTIVE);
  assign sclk_s      = sclk_sync[1];
  assign mosi_s      = mosi_sync[1];
  assign sclk_edge   = (sclk_s != sclk_prev);
  assign lead_edge   = sclk_edge && (sclk_s != CPOL);
  assign trail_edge  = sclk_edge && (sclk_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign start       = ss_act && !ss_act_prev && armed_q;

  function automatic logic [GPIO_W-1:0] rd_mux(input logic [2:0] a);
    case (a)
      3'd0:    rd_mux = out_q;
      3'd1:    rd_mux = dir_q;
      3'd2:    rd_mux = gin_sync;
      3'd3:    rd_mux = mask_q;
      3'd4:    rd_mux = status_q;
      3'd5:    rd_mux = IdVal;
      default: rd_mux = '0;
    endcase
  endfunction

  always_comb begin
    tx_load = 8'h00;
    for (int b = 0; b < NB; b++) begin
      if (byte_cnt_q == 2'(b)) tx_load = snap_q[b*8 +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    wr_d       = wr_q;
    first_d    = first_q;
    shadow_d   = shadow_q;
    snap_d     = snap_q;
    out_d      = out_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    armed_d    = armed_q | ~ss_act;
    irq_d      = |status_q;
    rx_byte    = {rx_q[6:0], mosi_s};
    merged     = shadow_q;
    w1c        = '0;
    addr_nx    = addr_q + 3'd1;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StCmd;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          shadow_d   = '0;
          tx_d       = 8'h5A;
          first_d    = CPHA;
        end
      end
      default: begin
        if (!ss_act) begin
          state_d = StIdle;
          tx_d    = 8'h00;
          first_d = 1'b0;
        end else begin
          if (sample_edge) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == StCmd) begin
                state_d    = StData;
                wr_d       = rx_byte[7];
                addr_d     = rx_byte[6:4];
                byte_cnt_d = '0;
                snap_d     = rd_mux(rx_byte[6:4]);
              end else begin
                for (int b = 0; b < NB; b++) begin
                  if (byte_cnt_q == 2'(b)) merged[b*8 +: 8] = rx_byte;
                end
                shadow_d = merged;
                if (byte_cnt_q == LastByte) begin
                  if (wr_q) begin
                    case (addr_q)
                      3'd0:    out_d  = merged;
                      3'd1:    dir_d  = merged;
                      3'd3:    mask_d = merged;
                      3'd4:    w1c    = merged;
                      default: ;
                    endcase
                  end
                  addr_d     = addr_nx;
                  byte_cnt_d = '0;
                  snap_d     = rd_mux(addr_nx);
                end else begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
                end
              end
            end
          end
          // A wrapped bit counter on a shift edge means a new byte starts on miso.
          if (shift_edge) begin
            if (first_q)                first_d = 1'b0;
            else if (bit_cnt_q == 3'd0) tx_d    = tx_load;
            else                        tx_d    = {tx_q[6:0], 1'b0};
          end
        end
      end
    endcase

    // Set wins over a simultaneous W1C clear.
    status_d = (status_q & ~w1c) | ((gin_sync ^ gin_prev) & mask_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      wr_q       <= 1'b0;
      first_q    <= 1'b0;
      armed_q    <= 1'b0;
      irq_q      <= 1'b0;
      shadow_q   <= '0;
      snap_q     <= '0;
      out_q      <= '0;
      dir_q      <= '0;
      mask_q     <= '0;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      wr_q       <= wr_d;
      first_q    <= first_d;
      armed_q    <= armed_d;
      irq_q      <= irq_d;
      shadow_q   <= shadow_d;
      snap_q     <= snap_d;
      out_q      <= out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      status_q   <= status_d;
    end
  end

  assign miso_oe  = ss_act && armed_q;
  assign miso     = miso_oe && !first_q && tx_q[7];
  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_spi_gpio_expander_p.sv
// Scoreboard bench for spi_gpio_expander_p: a mode-0 instance and a mode-3 instance share
// clock, reset and gpio_in; miso bytes and pin states are checked by separate monitors.
module tb_spi_gpio_expander_p;
  localparam int H = 8;

  typedef struct {
    bit         chk;
    logic [7:0] v;
  } miso_exp_t;

  typedef struct {
    string       name;
    int          dev;
    logic [15:0] out;
    logic [15:0] oe;
    logic        irq;
    logic        moe;
  } pin_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ss0 = 1'b0, sclk0 = 1'b0, mosi0 = 1'b0;
  logic ss1 = 1'b0, sclk1 = 1'b1, mosi1 = 1'b0;
  logic miso0, miso_oe0, irq0, miso1, miso_oe1, irq1;
  logic [15:0] gpio_in = 16'h0000;
  logic [15:0] gpio_out0, gpio_oe0, gpio_out1, gpio_oe1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b1;
  bit pbusy  = 1'b0;
  miso_exp_t  miso_q[$];
  pin_exp_t   pin_q[$];
  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  always #5 clk = ~clk;

  spi_gpio_expander_p u_dut0 (
    .clk(clk), .rst(rst), .ss(ss0), .sclk(sclk0), .mosi(mosi0), .miso(miso0),
    .miso_oe(miso_oe0), .gpio_in(gpio_in), .gpio_out(gpio_out0), .gpio_oe(gpio_oe0), .irq(irq0)
  );

  spi_gpio_expander_p #(.GPIO_W(16), .CPOL(1'b1), .CPHA(1'b1), .SS_ACTIVE(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .ss(ss1), .sclk(sclk1), .mosi(mosi1), .miso(miso1),
    .miso_oe(miso_oe1), .gpio_in(gpio_in), .gpio_out(gpio_out1), .gpio_oe(gpio_oe1), .irq(irq1)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ss(input int dev, input logic v);
    if (dev == 0) ss0 = v; else ss1 = v;
  endtask

  task automatic set_sclk(input int dev, input logic v);
    if (dev == 0) sclk0 = v; else sclk1 = v;
  endtask

  task automatic set_mosi(input int dev, input logic v);
    if (dev == 0) mosi0 = v; else mosi1 = v;
  endtask

  // dev 0 is mode 0 (idle low, sample leading); dev 1 is mode 3 (idle high, sample trailing).
  task automatic bit_xfer(input int dev, input logic b);
    if (dev == 0) begin
      set_mosi(dev, b);
      tick(H);
      set_sclk(dev, 1'b1);
      tick(H);
      set_sclk(dev, 1'b0);
    end else begin
      set_sclk(dev, 1'b0);
      set_mosi(dev, b);
      tick(H);
      set_sclk(dev, 1'b1);
      tick(H);
    end
  endtask

  task automatic send_bytes(input int dev);
    logic [7:0] b;
    for (int i = 0; i < txq.size(); i++) begin
      b = txq[i];
      for (int k = 7; k >= 0; k--) bit_xfer(dev, b[k]);
    end
  endtask

  // Full frame from txq; for dev 0 the marker and, if rd, the rxq bytes are expected on miso.
  task automatic frame(input int dev, input bit rd);
    miso_exp_t me;
    if (dev == 0) begin
      for (int i = 0; i < txq.size(); i++) begin
        me.chk = (i == 0) || rd;
        me.v   = (i == 0) ? 8'h5A : (rd ? rxq[i-1] : 8'h00);
        miso_q.push_back(me);
      end
    end
    set_ss(dev, 1'b1);
    tick(H);
    send_bytes(dev);
    tick(H);
    set_ss(dev, 1'b0);
    tick(2 * H);
  endtask

  task automatic expect_pins(input string nm, input int dev, input logic [15:0] o,
                             input logic [15:0] e, input logic iq, input logic moe);
    pin_exp_t p;
    bit done;
    p.name = nm; p.dev = dev; p.out = o; p.oe = e; p.irq = iq; p.moe = moe;
    pin_q.push_back(p);
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      if (pin_q.size() == 0 && !pbusy) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: pin monitor still busy, required idle within 100 cycles", nm);
    end
  endtask

  // Pin monitor: waits a short bounded window for the DUT pins to present the expected state.
  initial begin
    pin_exp_t p;
    logic [15:0] ao, ae;
    logic ai, am;
    bit ok;
    forever begin
      @(negedge clk);
      if (pin_q.size() != 0) begin
        pbusy = 1'b1;
        p = pin_q.pop_front();
        ok = 1'b0;
        ao = '0; ae = '0; ai = 1'b0; am = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
          @(negedge clk);
          ao = (p.dev == 0) ? gpio_out0 : gpio_out1;
          ae = (p.dev == 0) ? gpio_oe0  : gpio_oe1;
          ai = (p.dev == 0) ? irq0      : irq1;
          am = (p.dev == 0) ? miso_oe0  : miso_oe1;
          ok = (ao === p.out) && (ae === p.oe) && (ai === p.irq) && (am === p.moe);
        end
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL %s: got out=%h oe=%h irq=%b miso_oe=%b, required out=%h oe=%h irq=%b miso_oe=%b",
                   p.name, ao, ae, ai, am, p.out, p.oe, p.irq, p.moe);
        end
        pbusy = 1'b0;
      end
    end
  end

  // miso monitor for the mode-0 instance: assembles bytes on rising sclk, pops expectations.
  initial begin
    logic [7:0] sh;
    int nb;
    miso_exp_t me;
    sh = 8'h00;
    nb = 0;
    forever begin
      @(posedge sclk0 or posedge ss0);
      if (!sclk0) begin
        nb = 0;
      end else if (ss0) begin
        sh = {sh[6:0], miso0};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (mon_en) begin
            if (miso_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL miso_unexpected: got byte %h, required no byte", sh);
            end else begin
              me = miso_q.pop_front();
              if (me.chk) begin
                checks++;
                if (sh !== me.v) begin
                  errors++;
                  $display("FAIL miso_byte: got %h, required %h", sh, me.v);
                end
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tick(3);
    expect_pins("reset_dev0", 0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    expect_pins("reset_dev1", 1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    tick(10);

    txq = {8'h80, 8'hC3, 8'hA5};
    frame(0, 1'b0);
    expect_pins("write_out", 0, 16'hA5C3, 16'h0000, 1'b0, 1'b0);

    txq = {8'h80, 8'hFF, 8'h00, 8'h0F, 8'h0F};
    frame(0, 1'b0);
    expect_pins("burst_mode0", 0, 16'h00FF, 16'h0F0F, 1'b0, 1'b0);
    frame(1, 1'b0);
    expect_pins("burst_mode3", 1, 16'h00FF, 16'h0F0F, 1'b0, 1'b0);

    gpio_in = 16'h1234;
    tick(10);
    txq = {8'h20, 8'h00, 8'h00};
    rxq = {8'h34, 8'h12};
    frame(0, 1'b1);
    txq = {8'h50, 8'h00, 8'h00};
    rxq = {8'h10, 8'h00};
    frame(0, 1'b1);

    txq = {8'h80, 8'hFF};
    frame(0, 1'b0);
    expect_pins("abort_keeps_out", 0, 16'h00FF, 16'h0F0F, 1'b0, 1'b0);
    txq = {8'h80, 8'hC3, 8'hA5};
    frame(0, 1'b0);
    expect_pins("after_abort", 0, 16'hA5C3, 16'h0F0F, 1'b0, 1'b0);

    txq = {8'hB0, 8'h08, 8'h00};
    frame(0, 1'b0);
    expect_pins("mask_no_irq", 0, 16'hA5C3, 16'h0F0F, 1'b0, 1'b0);
    gpio_in = 16'h123C;
    expect_pins("irq_set", 0, 16'hA5C3, 16'h0F0F, 1'b1, 1'b0);
    txq = {8'h40, 8'h00, 8'h00};
    rxq = {8'h08, 8'h00};
    frame(0, 1'b1);
    gpio_in = 16'h1238;
    tick(10);
    frame(0, 1'b1);
    expect_pins("masked_bit_ignored", 0, 16'hA5C3, 16'h0F0F, 1'b1, 1'b0);
    txq = {8'hC0, 8'h08, 8'h00};
    frame(0, 1'b0);
    expect_pins("w1c_clear", 0, 16'hA5C3, 16'h0F0F, 1'b0, 1'b0);
    txq = {8'h40, 8'h00, 8'h00};
    rxq = {8'h00, 8'h00};
    frame(0, 1'b1);

    // Re-arm the interrupt, then reset in the middle of a frame.
    gpio_in = 16'h1230;
    expect_pins("irq_rearm", 0, 16'hA5C3, 16'h0F0F, 1'b1, 1'b0);
    mon_en = 1'b0;
    set_ss(0, 1'b1);
    tick(H);
    for (int k = 0; k < 4; k++) bit_xfer(0, 1'b1);
    rst = 1'b1;
    expect_pins("midframe_reset_dev0", 0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    expect_pins("midframe_reset_dev1", 1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    tick(5);
    txq = {8'h80, 8'h12, 8'h34};
    send_bytes(0);
    tick(H);
    expect_pins("frame_without_reassert", 0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    set_ss(0, 1'b0);
    tick(2 * H);
    mon_en = 1'b1;
    txq = {8'h80, 8'hC3, 8'hA5};
    frame(0, 1'b0);
    expect_pins("post_reset_write", 0, 16'hA5C3, 16'h0000, 1'b0, 1'b0);

    if (miso_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL miso_drain: %0d bytes outstanding, required 0", miso_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
